// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 hex keypad scanner: FSM states, key code map and a
// priority helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Indexed [row][col]; matches the silkscreen of the hex keypad.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [1:0] col_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency.
// No flow control: samples every clock.
module synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce and single-key lock-out.
// Press accepted DEBOUNCE_CYCLES after capture; no backpressure, key_valid is a strobe.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 20000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       press,
    output logic [3:0] digit0,
    output logic [3:0] digit1
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       cols_s;
    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] dwell;
    logic [DEB_W-1:0] cnt;
    logic [1:0]       cap_row;
    logic [1:0]       cap_col;
    logic             cap_bit;
    logic             dwell_end;
    logic             cnt_end;
    logic             do_capture;
    logic             do_rotate;
    logic             do_accept;

    synchronizer #(.WIDTH(4)) u_cols_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols),
        .q     (cols_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SCAN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_rotate  = 1'b0;
        do_accept  = 1'b0;
        cap_bit    = cols_s[cap_col];
        dwell_end  = (dwell == DWELL_LAST);
        cnt_end    = (cnt == DEB_LAST);
        case (state)
            SCAN: begin
                if (dwell_end) begin
                    if (|cols_s) begin
                        do_capture = 1'b1;
                        state_nxt  = DEBOUNCE;
                    end else begin
                        do_rotate = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!cap_bit) begin
                    state_nxt = SCAN;
                    do_rotate = 1'b1;
                end else if (cnt_end) begin
                    state_nxt = HELD;
                    do_accept = 1'b1;
                end
            end
            HELD: begin
                if (!cap_bit) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (cap_bit) begin
                    state_nxt = HELD;
                end else if (cnt_end) begin
                    state_nxt = SCAN;
                    do_rotate = 1'b1;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // Both counters saturate; every state change restarts the debounce count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell     <= '0;
            cnt       <= '0;
            rows      <= 4'b0001;
            cap_row   <= 2'd0;
            cap_col   <= 2'd0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            press     <= 1'b0;
            digit0    <= 4'h0;
            digit1    <= 4'h0;
        end else begin
            if (do_rotate)                     dwell <= '0;
            else if (state == SCAN && !dwell_end) dwell <= dwell + 1'b1;

            if (state_nxt != state) cnt <= '0;
            else if (!cnt_end)      cnt <= cnt + 1'b1;

            if (do_rotate) rows <= {rows[2:0], rows[3]};

            if (do_capture) begin
                cap_row <= col_index(rows);
                cap_col <= col_index(cols_s);
            end

            key_valid <= do_accept;
            if (do_accept) begin
                key    <= KEYMAP[cap_row][cap_col];
                digit1 <= digit0;
                digit0 <= KEYMAP[cap_row][cap_col];
            end

            press <= (state_nxt == HELD) || (state_nxt == RELEASE);
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl against a behavioural keypad
// and scanner model; every cycle's outputs are compared.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DB = 8;

    localparam int M_SCAN = 0;
    localparam int M_CONF = 1;
    localparam int M_HOLD = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols = 4'h0;
    logic [3:0] rows;
    logic [3:0] key;
    logic       key_valid;
    logic       press;
    logic [3:0] digit0;
    logic [3:0] digit1;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key       (key),
        .key_valid (key_valid),
        .press     (press),
        .digit0    (digit0),
        .digit1    (digit1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int kv_cnt  = 0;

    // Physical keypad: held[row*4+col]
    bit         held [16];
    logic [3:0] tb_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    // Reference model state
    int         m_mode, m_row, m_dwell, m_run, m_crow, m_ccol;
    logic [3:0] m_s1, m_s2, m_key, m_d0, m_d1;
    bit         m_kv, m_press;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] keypad_cols(input logic [3:0] r);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (r[i] && held[i*4+j]) c[j] = 1'b1;
        return c;
    endfunction

    task automatic model_reset();
        m_mode = M_SCAN; m_row = 0; m_dwell = 0; m_run = 0; m_crow = 0; m_ccol = 0;
        m_s1 = 4'h0; m_s2 = 4'h0; m_key = 4'h0; m_d0 = 4'h0; m_d1 = 4'h0;
        m_kv = 1'b0; m_press = 1'b0;
    endtask

    task automatic model_next_row();
        m_row   = (m_row + 1) % 4;
        m_dwell = 0;
        m_mode  = M_SCAN;
    endtask

    // One clock edge: decisions use the synchronized sample seen before the edge.
    task automatic model_step();
        logic [3:0] s;
        s    = m_s2;
        m_kv = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (m_dwell == SD - 1) begin
                    if (s != 0) begin
                        m_crow = m_row;
                        m_ccol = 3;
                        for (int j = 3; j >= 0; j--) if (s[j]) m_ccol = j;
                        m_run  = 0;
                        m_mode = M_CONF;
                    end else begin
                        model_next_row();
                    end
                end else begin
                    m_dwell++;
                end
            end
            M_CONF: begin
                if (!s[m_ccol]) model_next_row();
                else begin
                    m_run++;
                    if (m_run == DB) begin
                        m_kv    = 1'b1;
                        m_key   = tb_map[m_crow*4+m_ccol];
                        m_d1    = m_d0;
                        m_d0    = m_key;
                        m_press = 1'b1;
                        m_mode  = M_HOLD;
                    end
                end
            end
            M_HOLD: begin
                if (!s[m_ccol]) begin
                    m_mode = M_REL;
                    m_run  = 0;
                end
            end
            default: begin
                if (s[m_ccol]) m_mode = M_HOLD;
                else begin
                    m_run++;
                    if (m_run == DB) begin
                        m_press = 1'b0;
                        model_next_row();
                    end
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = cols;
    endtask

    task automatic tick();
        logic [3:0] exp_rows;
        cols = keypad_cols(rows);
        @(posedge clk);
        if (reset) model_step();
        else       model_reset();
        @(negedge clk);
        exp_rows = 4'b0001 << m_row;
        check("rows", rows, exp_rows);
        check("key", key, m_key);
        check("key_valid", key_valid, m_kv);
        check("press", press, m_press);
        check("digit0", digit0, m_d0);
        check("digit1", digit1, m_d1);
        if (key_valid) kv_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_all();
        for (int i = 0; i < 16; i++) held[i] = 1'b0;
    endtask

    task automatic wait_kv(input string tag, input int bound);
        int start;
        start = kv_cnt;
        for (int i = 0; i < bound && kv_cnt == start; i++) tick();
        check(tag, kv_cnt > start, 1);
    endtask

    task automatic wait_rows(input logic [3:0] r, input int bound);
        for (int i = 0; i < bound && rows != r; i++) tick();
    endtask

    int base;
    int r, c, r2, c2;

    initial begin
        release_all();
        model_reset();
        @(negedge clk);
        check("rst_rows", rows, 4'b0001);
        check("rst_press", press, 0);
        ticks(3);
        reset = 1'b1;

        // Idle scan
        ticks(40);
        check("idle_kv", kv_cnt, 0);

        // Key 6 held, then released
        held[1*4+2] = 1'b1;
        ticks(45);
        held[1*4+2] = 1'b0;
        ticks(30);
        check("k6_count", kv_cnt, 1);
        check("k6_key", key, 4'h6);
        check("k6_d0", digit0, 4'h6);
        check("k6_d1", digit1, 4'h0);

        // Short press on row0 aborts debounce
        base = kv_cnt;
        wait_rows(4'b1000, 40);
        wait_rows(4'b0001, 40);
        held[0] = 1'b1;
        ticks(5);
        held[0] = 1'b0;
        ticks(20);
        check("bounce_count", kv_cnt, base);

        // Release bounce: a single accepted press
        base = kv_cnt;
        held[0] = 1'b1;
        wait_kv("rb_accept", 100);
        ticks(5);
        held[0] = 1'b0;
        ticks(3);
        held[0] = 1'b1;
        ticks(10);
        held[0] = 1'b0;
        ticks(30);
        check("rb_count", kv_cnt, base + 1);
        check("rb_key", key, 4'h1);

        // Two-key sequence 5 then F
        held[1*4+1] = 1'b1;
        wait_kv("k5_accept", 100);
        held[1*4+1] = 1'b0;
        ticks(30);
        held[3*4+2] = 1'b1;
        wait_kv("kf_accept", 100);
        held[3*4+2] = 1'b0;
        ticks(30);
        check("seq_d1", digit1, 4'h5);
        check("seq_d0", digit0, 4'hF);

        // Simultaneous columns 1 and 2 on row3 lock column 1
        held[3*4+1] = 1'b1;
        held[3*4+2] = 1'b1;
        wait_kv("dual_accept", 100);
        check("dual_key", key, 4'h0);
        ticks(20);
        release_all();
        ticks(30);

        // Reset during debounce
        held[2*4+0] = 1'b1;
        for (int i = 0; i < 100 && m_mode != M_CONF; i++) tick();
        ticks(3);
        reset = 1'b0;
        #1;
        check("arst_rows", rows, 4'b0001);
        check("arst_key", key, 4'h0);
        check("arst_kv", key_valid, 0);
        check("arst_press", press, 0);
        check("arst_d0", digit0, 4'h0);
        check("arst_d1", digit1, 4'h0);
        model_reset();
        release_all();
        ticks(4);
        reset = 1'b1;
        base = kv_cnt;
        ticks(60);
        check("arst_nokv", kv_cnt, base);

        // Random presses, glitches, release bounces and extra keys
        for (int ep = 0; ep < 30; ep++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            held[r*4+c] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                r2 = $urandom_range(0, 3);
                c2 = $urandom_range(0, 3);
                ticks($urandom_range(1, 10));
                held[r2*4+c2] = 1'b1;
            end
            if ($urandom_range(0, 1) == 0) ticks($urandom_range(1, 6));
            else                           ticks($urandom_range(12, 40));
            release_all();
            if ($urandom_range(0, 2) == 0) begin
                ticks($urandom_range(1, 6));
                held[r*4+c] = 1'b1;
                ticks($urandom_range(2, 20));
                release_all();
            end
            ticks($urandom_range(0, 30));
        end
        release_all();
        ticks(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
